// File: rtl/ppa_pkg.sv
// Shared types and widths for the prefix-adder wrappers.
package ppa_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LOG2W = $clog2(WIDTH);
  localparam int unsigned CNT_W = 16;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [CNT_W-1:0] count_t;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_t;

endpackage

// File: rtl/sklansky_32bits.sv
// 32-bit Sklansky (divide-and-conquer) parallel-prefix adder, fully combinational.
module sklansky_32bits
  import ppa_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  logic  cin,
  output word_t sum,
  output logic  cout
);

  word_t half;
  word_t grp_g;
  word_t grp_p;

  // Prefix tree: after level l, bit i holds generate/propagate of its 2^(l+1)-aligned group down to bit 0.
  always_comb begin
    half  = a ^ b;
    grp_g = a & b;
    grp_p = half;
    // Fold carry-in into bit 0 so every group reaching bit 0 already includes it.
    grp_g[0] = grp_g[0] | (grp_p[0] & cin);
    for (int l = 0; l < int'(LOG2W); l++) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (((i >> l) & 1) == 1) begin
          grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[((i >> l) << l) - 1]);
          grp_p[i] = grp_p[i] & grp_p[((i >> l) << l) - 1];
        end
      end
    end
    sum  = half ^ {grp_g[WIDTH-2:0], cin};
    cout = grp_g[WIDTH-1];
  end

endmodule

// File: rtl/ppa_stream_accumulator.sv
// Streaming add/subtract accumulator around the Sklansky prefix adder.
module ppa_stream_accumulator
  import ppa_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam count_t CNT_MAX = '1;

  acc_state_t state;
  acc_state_t state_nxt;
  word_t      acc;
  count_t     count;
  logic       carry_st;
  logic       ovf_st;

  word_t      b_op;
  word_t      sum;
  logic       cout;
  logic       accept;

  // Subtraction as A + ~B + 1.
  assign b_op   = in_sub ? ~in_data : in_data;
  assign accept = in_valid & in_ready;

  sklansky_32bits u_adder (
    .a   (acc),
    .b   (b_op),
    .cin (in_sub),
    .sum (sum),
    .cout(cout)
  );

  // State and datapath registers: accumulate on accept, clear when the result is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ACC;
      acc      <= '0;
      count    <= '0;
      carry_st <= 1'b0;
      ovf_st   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc      <= sum;
        count    <= (count == CNT_MAX) ? count : count + CNT_W'(1);
        carry_st <= carry_st | (in_sub ? ~cout : cout);
        ovf_st   <= ovf_st | ((acc[WIDTH-1] == b_op[WIDTH-1]) & (sum[WIDTH-1] != acc[WIDTH-1]));
      end else if ((state == HOLD) && out_ready) begin
        acc      <= '0;
        count    <= '0;
        carry_st <= 1'b0;
        ovf_st   <= 1'b0;
      end
    end
  end

  // Next state: ACC until the last beat is accepted, HOLD until the result is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (accept && in_last) state_nxt = HOLD;
      HOLD:    if (out_ready)         state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // Handshake outputs decode state only; result outputs come straight from registers.
  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);
  assign out_sum   = acc;
  assign out_count = count;
  assign out_carry = carry_st;
  assign out_ovf   = ovf_st;

endmodule

// File: doc/ppa_stream_accumulator.md
# ppa_stream_accumulator

Sequential accumulation stage built around the 32-bit Sklansky prefix adder. It accepts a stream of operands over a valid/ready handshake and adds or subtracts each one into a running register. On the beat flagged last, it presents the final sum, a beat count and sticky carry/overflow flags over a second valid/ready handshake. It is the registered front end that feeds the combinational prefix adder and captures what the adder produces.

## Interface
- `WIDTH`, 32: operand/accumulator width; fixed at 32 to match the adder core.
- `CNT_W`, 16: beat-counter width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `in_valid` in 1: operand beat present.
- `in_ready` out 1: stage accepts a beat this cycle.
- `in_data` in WIDTH: operand.
- `in_sub` in 1: 1 = subtract `in_data` from the accumulator, 0 = add it.
- `in_last` in 1: final beat of the current stream.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer takes the result.
- `out_sum` out WIDTH: accumulated result, modulo 2^WIDTH.
- `out_count` out CNT_W: number of accepted beats, saturating.
- `out_carry` out 1: sticky unsigned carry-out (add) or borrow (sub).
- `out_ovf` out 1: sticky two's-complement overflow.

## Operation
- FSM states: ACC and HOLD.
  - Reset enters ACC.
  - ACC: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Adder core:
  - `A` = `acc`.
  - `B` = `in_sub` ? ~`in_data` : `in_data`.
  - `Cin` = `in_sub`.
  - The core is combinational; its result is used only on the accept edge.
- Accept, when `in_valid`&`in_ready`:
  - `acc` <= `S`.
  - `count` <= `count`+1, saturating at 2^CNT_W−1.
  - `carry_st` |= (`in_sub` ? ~`Cout` : `Cout`).
  - `ovf_st` |= (`acc`[31]==`B`[31]) & (`S`[31]!=`acc`[31]).
  - If `in_last`=1, the FSM moves to HOLD.
- HOLD:
  - `out_sum`, `out_count`, `out_carry`, `out_ovf` are driven straight from the state registers and stay stable until handshake.
  - On `out_ready`=1: `acc`, `count` and both stickies clear to 0; the FSM returns to ACC.
- `in_sub` and `in_last` are sampled only on accept. They are don't-care otherwise.
- Beats with `in_valid`=0 leave all state unchanged.
- Stream of one beat: allowed. The result is 0 ± `in_data`, with flags computed against `acc`=0.
- Empty stream does not exist: HOLD is reachable only through an accepted beat with `in_last`=1.
- Counter saturation does not set `out_ovf` or `out_carry`.

## Timing
- Reset values (`rst_n`=0 at an edge): state=ACC, `acc`=0, `count`=0, stickies=0.
  - Outputs after reset: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_count`=0, `out_carry`=0, `out_ovf`=0.
- Throughput is 1 beat/cycle in ACC.
- Latency:
  - `out_valid` rises on the cycle after the accepted last beat.
  - `out_sum` already includes that beat.
- `in_ready` is low for the entire HOLD, including the cycle in which `out_ready` is sampled high. The next operand can be accepted on the following cycle, so there is a minimum 1-cycle bubble between streams.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`. Both ready/valid outputs are pure functions of state.
- Reset mid-stream or in HOLD discards the partial result. No output is produced for the aborted stream.
- Critical path: `acc` → prefix adder → `acc`. Target is one adder delay plus the B-inversion mux.

## Structure
- Package `ppa_pkg`:
  - `localparam WIDTH=32`.
  - typedef `word_t` (logic [WIDTH-1:0]).
  - enum `acc_state_t` {ACC, HOLD}.
  - Reused by the other prefix-adder wrappers.
- Single sub-module: `sklansky_32bits`, instantiated once as the datapath adder. No other hierarchy.
- Flags and FSM logic are inline, in one `always_ff` and one `always_comb`.

## Test plan
- **Simple sum:** reset, then beats 5, 7, 10 (last) with `in_sub`=0, `out_ready`=1 → one cycle after the last beat: `out_sum`=22, `out_count`=3, `out_carry`=0, `out_ovf`=0. The next cycle is back in ACC with `acc`=0.
- **Unsigned wrap:** 0xFFFF_FFFF then 0x0000_0002 (last) → `out_sum`=1, `out_carry`=1, `out_ovf`=0.
- **Signed overflow and subtract:**
  - 0x7FFF_FFFF, then +1 (last) → `out_sum`=0x8000_0000, `out_ovf`=1.
  - Separate stream: 3, then sub 5 (last) → `out_sum`=0xFFFF_FFFE, `out_carry`=1 (borrow), `out_ovf`=0.
- **Backpressure:** hold `out_ready`=0 for 4 cycles in HOLD with `in_valid`=1 → `in_ready`=0 throughout, outputs stable, no beat accepted. After `out_ready`=1, the next beat is accepted one cycle later.
- **Reset mid-stream:** accept 100, 200, then `rst_n`=0 for one edge, then 9 (last) → `out_sum`=9, `out_count`=1.
- **Random:** 10k random streams of 1–40 beats with random add/sub and random valid/ready gaps, checked against a reference model of modulo-2^32 sum, saturating count and sticky flags.
